udp_packet_generator: RTL and testbench

Parametrised UDP traffic source that drives the payload and header inputs of the UDP stack (udp_complete_wrapper) directly. It generalises the fixed one-byte-per-packet test source to a configurable datapath width, runtime payload length, inter-packet gap, packet count and data pattern. Header fields are latched per packet. Used for link bring-up, checksum debug and throughput measurement.

---
 rtl/udp_gen_pkg.sv | 21 ++
 rtl/udp_gen_beat_counter.sv | 36 +++
 rtl/udp_packet_generator.sv | 237 +++++++++++++++++++++++
 tb/tb_udp_packet_generator.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_gen_pkg.sv
// Shared types and helpers for the UDP traffic generator.
package udp_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_GAP
  } gen_state_e;

  localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

  // Low `remainder` lanes set; a zero remainder means a completely full beat.
  function automatic logic [63:0] keep_mask(input logic [15:0] remainder);
    logic [63:0] mask;
    if (remainder == 16'd0) mask = '1;
    else                    mask = (64'd1 << remainder) - 64'd1;
    return mask;
  endfunction

endpackage

// File: rtl/udp_gen_beat_counter.sv
// Tracks payload bytes still to send in the current packet and derives the
// byte enables, last flag and valid byte count of the beat on the bus.
module udp_gen_beat_counter
  import udp_gen_pkg::*;
#(
  parameter int KEEP_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [15:0]           load_len,
  input  logic                  advance,
  output logic [KEEP_WIDTH-1:0] keep,
  output logic                  last,
  output logic [15:0]           valid_bytes
);

  localparam logic [15:0] KW = 16'(KEEP_WIDTH);

  logic [15:0] remaining_q, remaining_d;

  always_comb begin
    last        = (remaining_q <= KW);
    valid_bytes = last ? remaining_q : KW;
    keep        = last ? KEEP_WIDTH'(keep_mask(remaining_q % KW)) : '1;
    remaining_d = remaining_q;
    if (load)         remaining_d = load_len;
    else if (advance) remaining_d = remaining_q - valid_bytes;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) remaining_q <= 16'd0;
    else        remaining_q <= remaining_d;
  end

endmodule

// File: rtl/udp_packet_generator.sv
// Configurable UDP traffic source: latches a header per packet, streams a
// byte-counter payload on AXI-Stream and spaces packets by a programmable gap.
module udp_packet_generator
  import udp_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int MAX_PAYLOAD = 1472,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   udp_sys_clk,
  input  logic                   system_reset_n,
  input  logic                   enable,
  input  logic [15:0]            cfg_payload_len,
  input  logic [15:0]            cfg_gap_cycles,
  input  logic [15:0]            cfg_packet_count,
  input  logic                   cfg_pattern_mode,
  input  logic [31:0]            cfg_src_ip,
  input  logic [31:0]            cfg_dst_ip,
  input  logic [15:0]            cfg_src_port,
  input  logic [15:0]            cfg_dst_port,
  input  logic [7:0]             cfg_ttl,
  output logic                   udp_hdr_valid,
  input  logic                   udp_hdr_ready,
  output logic [31:0]            udp_ip_source_ip,
  output logic [31:0]            udp_ip_dest_ip,
  output logic [15:0]            udp_source_port,
  output logic [15:0]            udp_dest_port,
  output logic [15:0]            udp_length,
  output logic [7:0]             udp_ip_ttl,
  output logic [5:0]             udp_ip_dscp,
  output logic [1:0]             udp_ip_ecn,
  output logic [15:0]            udp_checksum,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] packets_sent
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  gen_state_e             state_q, state_d;
  logic                   hdr_valid_q, hdr_valid_d, tvalid_q, tvalid_d;
  logic                   busy_q, busy_d, done_q, done_d, mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] packets_sent_q, packets_sent_d;
  logic [15:0]            run_count_q, run_count_d, gap_cnt_q, gap_cnt_d;
  logic [15:0]            gap_q, gap_d, count_q, count_d, udp_len_q, udp_len_d;
  logic [15:0]            src_port_q, src_port_d, dst_port_q, dst_port_d;
  logic [31:0]            src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [7:0]             ttl_q, ttl_d, byte_cnt_q, byte_cnt_d;
  logic [15:0]            eff_len, run_total, beat_bytes;
  logic                   start_pkt, finish_pkt, beat_accept, beat_last;
  logic [KEEP_WIDTH-1:0]  beat_keep;

  always_comb begin
    if (cfg_payload_len == 16'd0)     eff_len = 16'd1;
    else if (cfg_payload_len > MAX_LEN) eff_len = MAX_LEN;
    else                              eff_len = cfg_payload_len;
  end

  assign beat_accept = tvalid_q & m_axis_tready;

  udp_gen_beat_counter #(.KEEP_WIDTH(KEEP_WIDTH)) u_beat_counter (
    .clk         (udp_sys_clk),
    .rst_n       (system_reset_n),
    .load        (start_pkt),
    .load_len    (eff_len),
    .advance     (beat_accept),
    .keep        (beat_keep),
    .last        (beat_last),
    .valid_bytes (beat_bytes)
  );

  always_comb begin
    state_d        = state_q;
    hdr_valid_d    = hdr_valid_q;
    tvalid_d       = tvalid_q;
    done_d         = done_q;
    packets_sent_d = packets_sent_q;
    run_count_d    = run_count_q;
    gap_cnt_d      = gap_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    src_ip_d       = src_ip_q;
    dst_ip_d       = dst_ip_q;
    src_port_d     = src_port_q;
    dst_port_d     = dst_port_q;
    ttl_d          = ttl_q;
    udp_len_d      = udp_len_q;
    gap_d          = gap_q;
    count_d        = count_q;
    mode_d         = mode_q;
    start_pkt      = 1'b0;
    finish_pkt     = 1'b0;
    run_total      = run_count_q;

    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          done_d = 1'b0;
        end else if (!done_q) begin
          start_pkt   = 1'b1;
          run_count_d = 16'd0;
        end
      end
      ST_HDR: begin
        if (udp_hdr_ready) begin
          state_d     = ST_PAYLOAD;
          hdr_valid_d = 1'b0;
          tvalid_d    = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (beat_accept) begin
          byte_cnt_d = 8'({8'd0, byte_cnt_q} + beat_bytes);
          if (beat_last) begin
            tvalid_d       = 1'b0;
            packets_sent_d = packets_sent_q + COUNT_WIDTH'(1);
            run_count_d    = run_count_q + 16'd1;
            if (mode_q) byte_cnt_d = 8'd0;
            if (gap_q != 16'd0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q - 16'd1;
            end else begin
              finish_pkt = 1'b1;
              run_total  = run_count_q + 16'd1;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 16'd0) finish_pkt = 1'b1;
        else                    gap_cnt_d  = gap_cnt_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // End of a packet (and its gap): stop on a completed finite run or a
    // dropped enable, otherwise chain straight into the next header.
    if (finish_pkt) begin
      if (count_q != 16'd0 && run_total == count_q) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else if (!enable) begin
        state_d = ST_IDLE;
      end else begin
        start_pkt = 1'b1;
      end
    end

    if (start_pkt) begin
      state_d     = ST_HDR;
      hdr_valid_d = 1'b1;
      src_ip_d    = cfg_src_ip;
      dst_ip_d    = cfg_dst_ip;
      src_port_d  = cfg_src_port;
      dst_port_d  = cfg_dst_port;
      ttl_d       = cfg_ttl;
      udp_len_d   = eff_len + UDP_HDR_BYTES;
      gap_d       = cfg_gap_cycles;
      count_d     = cfg_packet_count;
      mode_d      = cfg_pattern_mode;
      if (cfg_pattern_mode) byte_cnt_d = 8'd0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q        <= ST_IDLE;
      hdr_valid_q    <= 1'b0;
      tvalid_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      packets_sent_q <= '0;
      run_count_q    <= 16'd0;
      gap_cnt_q      <= 16'd0;
      byte_cnt_q     <= 8'd0;
      src_ip_q       <= 32'd0;
      dst_ip_q       <= 32'd0;
      src_port_q     <= 16'd0;
      dst_port_q     <= 16'd0;
      ttl_q          <= 8'd0;
      udp_len_q      <= 16'd0;
      gap_q          <= 16'd0;
      count_q        <= 16'd0;
      mode_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_valid_q    <= hdr_valid_d;
      tvalid_q       <= tvalid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      packets_sent_q <= packets_sent_d;
      run_count_q    <= run_count_d;
      gap_cnt_q      <= gap_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      src_ip_q       <= src_ip_d;
      dst_ip_q       <= dst_ip_d;
      src_port_q     <= src_port_d;
      dst_port_q     <= dst_port_d;
      ttl_q          <= ttl_d;
      udp_len_q      <= udp_len_d;
      gap_q          <= gap_d;
      count_q        <= count_d;
      mode_q         <= mode_d;
    end
  end

  for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
    assign m_axis_tdata[gi*8 +: 8] = tvalid_q ? byte_cnt_q + 8'(gi) : 8'd0;
  end

  assign m_axis_tkeep     = tvalid_q ? beat_keep : '0;
  assign m_axis_tlast     = tvalid_q & beat_last;
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tuser     = 1'b0;
  assign udp_hdr_valid    = hdr_valid_q;
  assign udp_ip_source_ip = src_ip_q;
  assign udp_ip_dest_ip   = dst_ip_q;
  assign udp_source_port  = src_port_q;
  assign udp_dest_port    = dst_port_q;
  assign udp_length       = udp_len_q;
  assign udp_ip_ttl       = ttl_q;
  assign udp_ip_dscp      = 6'd0;
  assign udp_ip_ecn       = 2'd0;
  assign udp_checksum     = 16'd0;
  assign busy             = busy_q;
  assign done             = done_q;
  assign packets_sent     = packets_sent_q;

endmodule

// File: tb/tb_udp_packet_generator.sv
// Directed self-checking bench: an 8-bit and a 32-bit generator share clock,
// reset and configuration; each scenario enables only one of them.
module tb_udp_packet_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_len = 16'd1, cfg_gap = 16'd0, cfg_cnt = 16'd0;
  logic        cfg_mode = 1'b0;
  logic [31:0] cfg_sip = 32'hC0A8_0001, cfg_dip = 32'hC0A8_0002;
  logic [15:0] cfg_sport = 16'd1234, cfg_dport = 16'd5678;
  logic [7:0]  cfg_ttl = 8'd64;

  logic        en8 = 1'b0, hrdy8 = 1'b1, trdy8 = 1'b1;
  logic        hv8, tv8, tl8, tu8, busy8, done8, tk8;
  logic [31:0] sip8, dip8, pk8;
  logic [15:0] sp8, dp8, len8, cs8;
  logic [7:0]  ttl8, td8;
  logic [5:0]  dscp8;
  logic [1:0]  ecn8;

  logic        en32 = 1'b0, hrdy32 = 1'b1, trdy32 = 1'b1;
  logic        hv32, tv32, tl32, tu32, busy32, done32;
  logic [31:0] sip32, dip32, pk32, td32;
  logic [15:0] sp32, dp32, len32, cs32;
  logic [7:0]  ttl32;
  logic [5:0]  dscp32;
  logic [1:0]  ecn32;
  logic [3:0]  tk32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  udp_packet_generator #(.DATA_WIDTH(8)) u_dut8 (
    .udp_sys_clk(clk), .system_reset_n(rst_n), .enable(en8),
    .cfg_payload_len(cfg_len), .cfg_gap_cycles(cfg_gap), .cfg_packet_count(cfg_cnt),
    .cfg_pattern_mode(cfg_mode), .cfg_src_ip(cfg_sip), .cfg_dst_ip(cfg_dip),
    .cfg_src_port(cfg_sport), .cfg_dst_port(cfg_dport), .cfg_ttl(cfg_ttl),
    .udp_hdr_valid(hv8), .udp_hdr_ready(hrdy8),
    .udp_ip_source_ip(sip8), .udp_ip_dest_ip(dip8), .udp_source_port(sp8),
    .udp_dest_port(dp8), .udp_length(len8), .udp_ip_ttl(ttl8), .udp_ip_dscp(dscp8),
    .udp_ip_ecn(ecn8), .udp_checksum(cs8),
    .m_axis_tdata(td8), .m_axis_tkeep(tk8), .m_axis_tvalid(tv8), .m_axis_tlast(tl8),
    .m_axis_tuser(tu8), .m_axis_tready(trdy8),
    .busy(busy8), .done(done8), .packets_sent(pk8)
  );

  udp_packet_generator #(.DATA_WIDTH(32)) u_dut32 (
    .udp_sys_clk(clk), .system_reset_n(rst_n), .enable(en32),
    .cfg_payload_len(cfg_len), .cfg_gap_cycles(cfg_gap), .cfg_packet_count(cfg_cnt),
    .cfg_pattern_mode(cfg_mode), .cfg_src_ip(cfg_sip), .cfg_dst_ip(cfg_dip),
    .cfg_src_port(cfg_sport), .cfg_dst_port(cfg_dport), .cfg_ttl(cfg_ttl),
    .udp_hdr_valid(hv32), .udp_hdr_ready(hrdy32),
    .udp_ip_source_ip(sip32), .udp_ip_dest_ip(dip32), .udp_source_port(sp32),
    .udp_dest_port(dp32), .udp_length(len32), .udp_ip_ttl(ttl32), .udp_ip_dscp(dscp32),
    .udp_ip_ecn(ecn32), .udp_checksum(cs32),
    .m_axis_tdata(td32), .m_axis_tkeep(tk32), .m_axis_tvalid(tv32), .m_axis_tlast(tl32),
    .m_axis_tuser(tu32), .m_axis_tready(trdy32),
    .busy(busy32), .done(done32), .packets_sent(pk32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({hv8, tv8, busy8, done8, hv32, tv32, busy32, done32} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {hv8, tv8, busy8, done8, hv32, tv32, busy32, done32});
    end
    checks++;
    if ({pk8, pk32} !== 64'd0) begin
      failures++;
      $display("FAIL reset_pkts: got %h want 0", {pk8, pk32});
    end
    checks++;
    if ({len8, len32, td8, td32} !== 72'd0) begin
      failures++;
      $display("FAIL reset_regs: got %h want 0", {len8, len32, td8, td32});
    end
    rst_n = 1'b1;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_single_byte();
    int n;
    cfg_len = 16'd1; cfg_cnt = 16'd3; cfg_gap = 16'd0; cfg_mode = 1'b0;
    en8 = 1'b1; hrdy8 = 1'b1; trdy8 = 1'b1;
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (!hv8 && n < 20) begin tick(); n++; end
      checks++;
      if (hv8 !== 1'b1) begin
        failures++;
        $display("FAIL w8_hdr_timeout: pkt %0d hdr_valid=%b want 1", p, hv8);
      end
      if (p == 0) begin
        checks++;
        if (n !== 1) begin
          failures++;
          $display("FAIL w8_hdr_latency: got %0d cycles want 1", n);
        end
        checks++;
        if ({sip8, dip8, sp8, dp8, ttl8, dscp8, ecn8, cs8} !==
            {32'hC0A8_0001, 32'hC0A8_0002, 16'd1234, 16'd5678, 8'd64, 6'd0, 2'd0, 16'd0}) begin
          failures++;
          $display("FAIL w8_hdr_fields: got %h", {sip8, dip8, sp8, dp8, ttl8, dscp8, ecn8, cs8});
        end
      end
      checks++;
      if (len8 !== 16'd9) begin
        failures++;
        $display("FAIL w8_udp_length: got %0d want 9", len8);
      end
      tick();
      checks++;
      if ({tv8, td8, tk8, tl8, tu8} !== {1'b1, 8'(p), 1'b1, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL w8_beat: pkt %0d got v=%b d=%h k=%b l=%b u=%b want v=1 d=%h k=1 l=1 u=0",
                 p, tv8, td8, tk8, tl8, tu8, 8'(p));
      end
      $display("test_single_byte: pkt %0d data=%h", p, td8);
      tick();
    end
    checks++;
    if ({done8, busy8, pk8} !== {1'b1, 1'b0, 32'd3}) begin
      failures++;
      $display("FAIL w8_run_end: got done=%b busy=%b pkts=%0d want done=1 busy=0 pkts=3",
               done8, busy8, pk8);
    end
    en8 = 1'b0;
    tick();
    checks++;
    if (done8 !== 1'b0) begin
      failures++;
      $display("FAIL w8_done_clear: got %b want 0", done8);
    end
  endtask

  task automatic test_width32_mode1();
    int n;
    cfg_len = 16'd6; cfg_cnt = 16'd2; cfg_gap = 16'd2; cfg_mode = 1'b1;
    cfg_sip = 32'h0A00_0001; cfg_dip = 32'h0A00_0002;
    cfg_sport = 16'h1000; cfg_dport = 16'h2000; cfg_ttl = 8'd17;
    en32 = 1'b1; hrdy32 = 1'b1; trdy32 = 1'b1;
    n = 0;
    while (!hv32 && n < 20) begin tick(); n++; end
    checks++;
    if ({hv32, len32} !== {1'b1, 16'd14}) begin
      failures++;
      $display("FAIL w32_hdr: got valid=%b len=%0d want valid=1 len=14", hv32, len32);
    end
    checks++;
    if ({sip32, dip32, sp32, dp32, ttl32, dscp32, ecn32, cs32} !==
        {32'h0A00_0001, 32'h0A00_0002, 16'h1000, 16'h2000, 8'd17, 6'd0, 2'd0, 16'd0}) begin
      failures++;
      $display("FAIL w32_hdr_fields: got %h", {sip32, dip32, sp32, dp32, ttl32, dscp32, ecn32, cs32});
    end
    tick();
    checks++;
    if ({tv32, td32, tk32, tl32, tu32} !== {1'b1, 32'h0302_0100, 4'hF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL w32_beat0: got v=%b d=%h k=%h l=%b want v=1 d=03020100 k=f l=0",
               tv32, td32, tk32, tl32);
    end
    tick();
    checks++;
    if ({tv32, td32, tk32, tl32, tu32} !== {1'b1, 32'h0706_0504, 4'h3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL w32_beat1: got v=%b d=%h k=%h l=%b want v=1 d=07060504 k=3 l=1",
               tv32, td32, tk32, tl32);
    end
    tick();
    checks++;
    if ({tv32, busy32, hv32} !== 3'b010) begin
      failures++;
      $display("FAIL w32_gap_idle: got v=%b busy=%b hv=%b want 0 1 0", tv32, busy32, hv32);
    end
    n = 0;
    while (!hv32 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL w32_gap_len: got %0d cycles want 2", n);
    end
    tick();
    checks++;
    if ({tv32, td32, tk32} !== {1'b1, 32'h0302_0100, 4'hF}) begin
      failures++;
      $display("FAIL w32_restart: got v=%b d=%h k=%h want v=1 d=03020100 k=f", tv32, td32, tk32);
    end
    $display("test_width32_mode1: pkt 1 beat0 data=%h", td32);
    tick();
    tick();
    n = 0;
    while (!done32 && n < 20) begin tick(); n++; end
    checks++;
    if ({done32, busy32, pk32} !== {1'b1, 1'b0, 32'd2}) begin
      failures++;
      $display("FAIL w32_run_end: got done=%b busy=%b pkts=%0d want 1 0 2", done32, busy32, pk32);
    end
    en32 = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int n, exp_b, bad_hold, bad_data;
    logic stalled, held_last;
    logic [7:0] held;
    cfg_len = 16'd10; cfg_cnt = 16'd1; cfg_gap = 16'd0; cfg_mode = 1'b1;
    en8 = 1'b1; hrdy8 = 1'b1; trdy8 = 1'b0;
    n = 0;
    while (!hv8 && n < 20) begin tick(); n++; end
    tick();
    exp_b = 0; bad_hold = 0; bad_data = 0; stalled = 1'b0; held = 8'd0; held_last = 1'b0;
    for (int i = 0; i < 60 && exp_b < 10; i++) begin
      trdy8 = (i % 2 == 1);
      if (stalled && (tv8 !== 1'b1 || td8 !== held || tl8 !== held_last)) bad_hold++;
      stalled = 1'b0;
      if (tv8 === 1'b1) begin
        if (trdy8) begin
          if (td8 !== 8'(exp_b) || tl8 !== (exp_b == 9)) bad_data++;
          $display("test_stall: accepted byte %h last=%b", td8, tl8);
          exp_b++;
        end else begin
          stalled = 1'b1; held = td8; held_last = tl8;
        end
      end
      tick();
    end
    trdy8 = 1'b1;
    checks++;
    if (exp_b !== 10) begin
      failures++;
      $display("FAIL stall_count: got %0d bytes want 10", exp_b);
    end
    checks++;
    if (bad_hold !== 0) begin
      failures++;
      $display("FAIL stall_hold: got %0d unstable cycles want 0", bad_hold);
    end
    checks++;
    if (bad_data !== 0) begin
      failures++;
      $display("FAIL stall_data: got %0d wrong bytes want 0", bad_data);
    end
    checks++;
    if ({done8, pk8} !== {1'b1, 32'd4}) begin
      failures++;
      $display("FAIL stall_end: got done=%b pkts=%0d want 1 4", done8, pk8);
    end
    en8 = 1'b0;
    tick();
  endtask

  task automatic test_clamp();
    int n, beats;
    logic [15:0] lens [2];
    logic [15:0] exp_len [2];
    int exp_beats [2];
    logic [3:0] exp_keep [2];
    logic [3:0] last_keep;
    lens[0] = 16'd0;    exp_len[0] = 16'd9;    exp_beats[0] = 1;   exp_keep[0] = 4'h1;
    lens[1] = 16'd2000; exp_len[1] = 16'd1480; exp_beats[1] = 368; exp_keep[1] = 4'hF;
    cfg_cnt = 16'd1; cfg_gap = 16'd0; cfg_mode = 1'b0;
    trdy32 = 1'b1; hrdy32 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cfg_len = lens[r];
      en32 = 1'b1;
      n = 0;
      while (!hv32 && n < 20) begin tick(); n++; end
      checks++;
      if ({hv32, len32} !== {1'b1, exp_len[r]}) begin
        failures++;
        $display("FAIL clamp_len: got valid=%b len=%0d want valid=1 len=%0d", hv32, len32, exp_len[r]);
      end
      tick();
      beats = 0; last_keep = 4'h0;
      for (int i = 0; i < 500; i++) begin
        if (tv32 === 1'b1) begin
          beats++;
          if (tl32 === 1'b1) begin
            last_keep = tk32;
            tick();
            break;
          end
        end
        tick();
      end
      checks++;
      if (beats !== exp_beats[r]) begin
        failures++;
        $display("FAIL clamp_beats: got %0d want %0d", beats, exp_beats[r]);
      end
      checks++;
      if (last_keep !== exp_keep[r]) begin
        failures++;
        $display("FAIL clamp_keep: got %h want %h", last_keep, exp_keep[r]);
      end
      $display("test_clamp: req %0d udp_length=%0d beats=%0d", lens[r], len32, beats);
      en32 = 1'b0;
      tick();
    end
  endtask

  task automatic test_enable_drop();
    int n, nbytes, bad;
    logic last_seen, saw_hdr;
    cfg_len = 16'd64; cfg_cnt = 16'd0; cfg_gap = 16'd3; cfg_mode = 1'b1;
    en8 = 1'b1; hrdy8 = 1'b1; trdy8 = 1'b1;
    n = 0;
    while (!hv8 && n < 20) begin tick(); n++; end
    tick();
    nbytes = 0; bad = 0; last_seen = 1'b0;
    for (int i = 0; i < 100 && !last_seen; i++) begin
      if (i == 10) en8 = 1'b0;
      if (tv8 === 1'b1) begin
        if (td8 !== 8'(nbytes)) bad++;
        nbytes++;
        if (tl8 === 1'b1) last_seen = 1'b1;
      end
      tick();
    end
    checks++;
    if ({last_seen, nbytes} !== {1'b1, 32'd64}) begin
      failures++;
      $display("FAIL drop_len: got last=%b bytes=%0d want last=1 bytes=64", last_seen, nbytes);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL drop_data: got %0d wrong bytes want 0", bad);
    end
    saw_hdr = 1'b0;
    n = 0;
    while (n < 12) begin
      if (hv8 === 1'b1) saw_hdr = 1'b1;
      tick();
      n++;
    end
    checks++;
    if ({busy8, done8, saw_hdr, tv8} !== 4'b0000) begin
      failures++;
      $display("FAIL drop_idle: got busy=%b done=%b hdr=%b v=%b want 0 0 0 0", busy8, done8, saw_hdr, tv8);
    end
    checks++;
    if (pk8 !== 32'd5) begin
      failures++;
      $display("FAIL drop_pkts: got %0d want 5", pk8);
    end
    $display("test_enable_drop: %0d bytes, packets_sent=%0d", nbytes, pk8);
  endtask

  task automatic test_reset_mid_payload();
    int n;
    cfg_len = 16'd20; cfg_cnt = 16'd0; cfg_gap = 16'd0; cfg_mode = 1'b0;
    en8 = 1'b1; hrdy8 = 1'b1; trdy8 = 1'b1;
    n = 0;
    while (!hv8 && n < 20) begin tick(); n++; end
    tick();
    tick();
    tick();
    checks++;
    if ({tv8, td8} !== {1'b1, 8'd2}) begin
      failures++;
      $display("FAIL rst_pre: got v=%b d=%h want v=1 d=02", tv8, td8);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tv8, hv8, busy8, pk8} !== {3'b000, 32'd0}) begin
      failures++;
      $display("FAIL rst_async: got v=%b hv=%b busy=%b pkts=%0d want 0 0 0 0", tv8, hv8, busy8, pk8);
    end
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!hv8 && n < 20) begin tick(); n++; end
    checks++;
    if (hv8 !== 1'b1) begin
      failures++;
      $display("FAIL rst_new_hdr: got %b want 1", hv8);
    end
    tick();
    checks++;
    if ({tv8, td8} !== {1'b1, 8'd0}) begin
      failures++;
      $display("FAIL rst_restart: got v=%b d=%h want v=1 d=00", tv8, td8);
    end
    $display("test_reset_mid_payload: restart data=%h", td8);
    en8 = 1'b0;
    n = 0;
    while (busy8 && n < 60) begin tick(); n++; end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_width32_mode1();
    test_stall();
    test_clamp();
    test_enable_drop();
    test_reset_mid_payload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
